sel_decoder_seq: RTL and testbench

- Parametrised, registered successor to the 4-to-16 register-select decoder in the datapath.
- Decodes an IN_W-bit select code into an OUT_W-bit select vector in three modes: one-hot, thermometer and auto-scan. Auto-scan walks codes for register dump/clear sequences.
- Valid/ready handshake on both sides; one output register stage; sits between control unit and register-file enables.

---
 rtl/sel_decoder_pkg.sv | 16 +
 rtl/sel_decoder_seq_if.sv | 25 ++
 rtl/sel_decode_comb.sv | 27 ++
 rtl/sel_decoder_seq.sv | 100 ++++++++++
 tb/tb_sel_decoder_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sel_decoder_pkg.sv
// Shared types for the registered select decoder.
package sel_decoder_pkg;

   typedef enum logic [1:0] {
      MODE_ONE_HOT = 2'b00,
      MODE_THERMO  = 2'b01,
      MODE_SCAN    = 2'b10,
      MODE_HOLD    = 2'b11
   } mode_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } scan_state_t;

endpackage

// File: rtl/sel_decoder_seq_if.sv
// Handshake bundle between control unit (master) and select decoder (slave).
interface sel_decoder_seq_if #(
   parameter int unsigned IN_W  = 4,
   parameter int unsigned OUT_W = 16
);
   logic [IN_W-1:0]  d_in;
   logic [1:0]       mode;
   logic             in_valid;
   logic             in_ready;
   logic [OUT_W-1:0] d_out;
   logic             out_valid;
   logic             out_ready;
   logic             scan_busy;
   logic             scan_done;

   modport master (
      output d_in, mode, in_valid, out_ready,
      input  in_ready, d_out, out_valid, scan_busy, scan_done
   );

   modport slave (
      input  d_in, mode, in_valid, out_ready,
      output in_ready, d_out, out_valid, scan_busy, scan_done
   );
endinterface

// File: rtl/sel_decode_comb.sv
// Combinational code -> select vector; any mode other than THERMO yields one-hot.
module sel_decode_comb
   import sel_decoder_pkg::*;
#(
   parameter int unsigned CODE_W   = 5,
   parameter int unsigned OUT_W    = 16,
   parameter bit          MASK_TOP = 1'b1
) (
   input  logic [CODE_W-1:0] code,
   input  mode_t             mode,
   output logic [OUT_W-1:0]  vec
);

   int unsigned code_u;

   // Build the vector, then blank it for out-of-range and masked top codes.
   always_comb begin
      vec    = '0;
      code_u = 32'(code);
      for (int unsigned i = 0; i < OUT_W; i++) begin
         if (mode == MODE_THERMO) vec[i] = (i <= code_u);
         else                     vec[i] = (i == code_u);
      end
      if (code_u >= OUT_W || (MASK_TOP && code_u == OUT_W - 1)) vec = '0;
   end

endmodule

// File: rtl/sel_decoder_seq.sv
// Registered select decoder with one-hot, thermometer, hold and auto-scan modes.
module sel_decoder_seq
   import sel_decoder_pkg::*;
#(
   parameter int unsigned IN_W     = 4,
   parameter int unsigned OUT_W    = 16,
   parameter bit          MASK_TOP = 1'b1
) (
   input  logic             clk,
   input  logic             clr,
   sel_decoder_seq_if.slave bus
);

   localparam int unsigned CNT_W = IN_W + 1;
   localparam int unsigned LAST  = MASK_TOP ? OUT_W - 2 : OUT_W - 1;

   scan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] d_out_q, d_out_d;
   logic             out_valid_q, out_valid_d;
   logic             done_q, done_d;
   logic [OUT_W-1:0] in_vec, cnt_vec;
   logic             ld, accept;
   mode_t            in_mode;

   assign in_mode      = mode_t'(bus.mode);
   assign ld           = !out_valid_q || bus.out_ready;
   assign bus.in_ready = ld && (state_q == S_IDLE);
   assign accept       = bus.in_valid && bus.in_ready;

   sel_decode_comb #(.CODE_W(CNT_W), .OUT_W(OUT_W), .MASK_TOP(MASK_TOP)) u_in_dec (
      .code ({1'b0, bus.d_in}),
      .mode (in_mode),
      .vec  (in_vec)
   );

   sel_decode_comb #(.CODE_W(CNT_W), .OUT_W(OUT_W), .MASK_TOP(MASK_TOP)) u_cnt_dec (
      .code (cnt_q),
      .mode (MODE_ONE_HOT),
      .vec  (cnt_vec)
   );

   // Next-state: scan beats take priority, otherwise load an accepted code.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      d_out_d     = d_out_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      if (ld) begin
         if (state_q == S_SCAN) begin
            d_out_d     = cnt_vec;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 1'b1;
            if (32'(cnt_q) == LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end else if (accept) begin
            out_valid_d = 1'b1;
            case (in_mode)
               MODE_HOLD: ;
               MODE_SCAN: begin
                  // Start code past LAST already decodes to zero: one done beat.
                  d_out_d = in_vec;
                  if (32'(bus.d_in) <= LAST) cnt_d = {1'b0, bus.d_in} + 1'b1;
                  if (32'(bus.d_in) < LAST) state_d = S_SCAN;
                  else                      done_d  = 1'b1;
               end
               default: d_out_d = in_vec;
            endcase
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State register with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         d_out_q     <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         d_out_q     <= d_out_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign bus.d_out     = d_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.scan_busy = (state_q == S_SCAN);
   assign bus.scan_done = done_q;

endmodule

// File: tb/tb_sel_decoder_seq.sv
// Scoreboard bench for sel_decoder_seq (16-bit main instance, 10-bit side instance).
module tb_sel_decoder_seq;
   import sel_decoder_pkg::*;

   typedef struct {
      logic [15:0] vec;
      logic        done;
   } beat_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   bit   tog_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   beat_t       sb[$];
   logic [15:0] model_last = '0;

   sel_decoder_seq_if #(.IN_W(4), .OUT_W(16)) bus ();
   sel_decoder_seq_if #(.IN_W(4), .OUT_W(10)) bus10 ();

   sel_decoder_seq #(.IN_W(4), .OUT_W(16), .MASK_TOP(1'b1)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   sel_decoder_seq #(.IN_W(4), .OUT_W(10), .MASK_TOP(1'b1)) dut10 (
      .clk (clk),
      .clr (clr),
      .bus (bus10)
   );

   logic [3:0] t10_code [4] = '{4'd12, 4'd8, 4'd9, 4'd8};
   logic [1:0] t10_mode [4] = '{MODE_THERMO, MODE_THERMO, MODE_THERMO, MODE_ONE_HOT};
   logic [9:0] t10_exp  [4] = '{10'h000, 10'h1FF, 10'h000, 10'h100};

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_vec(input int unsigned code, input logic [1:0] m);
      logic [31:0] t;
      if (code >= 15) return '0;
      if (m == MODE_THERMO) t = (32'd1 << (code + 1)) - 32'd1;
      else                  t = 32'd1 << code;
      return t[15:0];
   endfunction

   task automatic push_beat(input logic [15:0] v, input logic d);
      beat_t b;
      b.vec  = v;
      b.done = d;
      sb.push_back(b);
      model_last = v;
   endtask

   task automatic push_expected(input int unsigned code, input logic [1:0] m);
      case (m)
         MODE_HOLD: push_beat(model_last, 1'b0);
         MODE_SCAN: begin
            if (code <= 14) begin
               for (int unsigned c = code; c <= 14; c++) begin
                  logic [31:0] oh;
                  oh = 32'd1 << c;
                  push_beat(oh[15:0], c == 14);
               end
            end else begin
               push_beat(16'h0000, 1'b1);
            end
         end
         default: push_beat(ref_vec(code, m), 1'b0);
      endcase
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [3:0] code, input logic [1:0] m);
      int unsigned n = 0;
      bus.d_in     = code;
      bus.mode     = m;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check_val("accept_timeout", 32'(bus.in_ready), 32'd1);
      else               push_expected(32'(code), m);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int unsigned n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_val(tag, 32'(sb.size()), 32'd0);
   endtask

   // Background out_ready toggling for the backpressure scan.
   always @(posedge clk) begin
      if (tog_en) begin
         #1;
         bus.out_ready = ~bus.out_ready;
      end
   end

   // Monitor: handshakes pop the scoreboard; stalled beats must not move.
   logic [15:0] stall_val  = '0;
   bit          stall_prev = 1'b0;
   bit          clr_prev   = 1'b0;
   logic        done_acc   = 1'b0;
   always @(negedge clk) begin
      beat_t e;
      if (stall_prev && !clr_prev) check_val("stall_hold", 32'(bus.d_out), 32'(stall_val));
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_val  = bus.d_out;
      clr_prev   = clr;
      if (clr) begin
         sb.delete();
         done_acc   = 1'b0;
         model_last = '0;
      end else begin
         done_acc = done_acc | bus.scan_done;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check_val("unexpected_beat", 32'(bus.d_out), 32'hDEAD_BEEF);
            end else begin
               e = sb.pop_front();
               check_val("beat_vec", 32'(bus.d_out), 32'(e.vec));
               check_val("beat_done", 32'(done_acc), 32'(e.done));
            end
            done_acc = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.d_in      = '0;
      bus.mode      = MODE_ONE_HOT;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus10.d_in      = '0;
      bus10.mode      = MODE_ONE_HOT;
      bus10.in_valid  = 1'b0;
      bus10.out_ready = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_d_out", 32'(bus.d_out), 32'd0);
      check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_scan_busy", 32'(bus.scan_busy), 32'd0);
      check_val("rst_scan_done", 32'(bus.scan_done), 32'd0);
      check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check_val("rst10_out_valid", 32'(bus10.out_valid), 32'd0);
      clr = 1'b0;
      bus.out_ready = 1'b1;

      // one-hot and thermometer
      send(4'd3, MODE_ONE_HOT);
      check_val("oh3_d_out", 32'(bus.d_out), 32'h0008);
      check_val("oh3_valid", 32'(bus.out_valid), 32'd1);
      send(4'd15, MODE_ONE_HOT);
      check_val("oh15_masked", 32'(bus.d_out), 32'h0000);
      send(4'd5, MODE_THERMO);
      check_val("th5_d_out", 32'(bus.d_out), 32'h003F);
      send(4'd14, MODE_THERMO);
      send(4'd0, MODE_ONE_HOT);
      wait_drain("drain_basic");

      // 10-bit instance range and mask rules
      for (int i = 0; i < 4; i++) begin
         bus10.d_in     = t10_code[i];
         bus10.mode     = t10_mode[i];
         bus10.in_valid = 1'b1;
         @(posedge clk);
         #1;
         check_val("w10_d_out", 32'(bus10.d_out), 32'(t10_exp[i]));
         check_val("w10_valid", 32'(bus10.out_valid), 32'd1);
      end
      bus10.in_valid = 1'b0;

      // short scan from 12
      send(4'd12, MODE_SCAN);
      check_val("scan12_b0", 32'(bus.d_out), 32'h1000);
      check_val("scan12_rdy0", 32'(bus.in_ready), 32'd0);
      check_val("scan12_busy", 32'(bus.scan_busy), 32'd1);
      @(posedge clk);
      #1;
      check_val("scan12_b1", 32'(bus.d_out), 32'h2000);
      check_val("scan12_rdy1", 32'(bus.in_ready), 32'd0);
      check_val("scan12_nodone", 32'(bus.scan_done), 32'd0);
      @(posedge clk);
      #1;
      check_val("scan12_b2", 32'(bus.d_out), 32'h4000);
      check_val("scan12_done", 32'(bus.scan_done), 32'd1);
      check_val("scan12_rdy2", 32'(bus.in_ready), 32'd1);
      wait_drain("drain_scan12");

      // scan at LAST and past LAST: single beats
      send(4'd14, MODE_SCAN);
      send(4'd15, MODE_SCAN);
      wait_drain("drain_scan_edge");

      // full scan under toggling backpressure
      send(4'd0, MODE_SCAN);
      tog_en = 1'b1;
      wait_drain("drain_scan_bp");
      tog_en = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      check_val("scan_bp_idle", 32'(bus.scan_busy), 32'd0);

      // clear in the middle of a scan
      send(4'd0, MODE_SCAN);
      repeat (8) @(posedge clk);
      #1;
      check_val("clr_pre_beat", 32'(bus.d_out), 32'h0100);
      clr = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      check_val("clr_d_out", 32'(bus.d_out), 32'd0);
      check_val("clr_valid", 32'(bus.out_valid), 32'd0);
      check_val("clr_busy", 32'(bus.scan_busy), 32'd0);
      check_val("clr_done", 32'(bus.scan_done), 32'd0);
      clr = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_val("clr_in_ready", 32'(bus.in_ready), 32'd1);
      check_val("clr_no_done", 32'(bus.scan_done), 32'd0);

      // hold and stalled input
      send(4'd7, MODE_ONE_HOT);
      send(4'd0, MODE_HOLD);
      check_val("hold_d_out", 32'(bus.d_out), 32'h0080);
      bus.out_ready = 1'b0;
      bus.d_in      = 4'd2;
      bus.mode      = MODE_ONE_HOT;
      bus.in_valid  = 1'b1;
      repeat (3) begin
         #1;
         check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk);
         #1;
         check_val("stall_d_out", 32'(bus.d_out), 32'h0080);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_val("post_hold_valid", 32'(bus.out_valid), 32'd0);
      check_val("post_hold_d_out", 32'(bus.d_out), 32'h0080);
      wait_drain("drain_final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
